// File: rtl/dm_responder_pkg.sv
// Shared types and widths for the data-memory responder and its byte-lane helper.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } dm_state_t;

  localparam int LANE_W = 2;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bundle between the multicycle controller (master) and the data-memory responder (slave).
interface dm_responder_if;
  logic        req;
  logic        we;
  logic        byteOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  modport master (output req, we, byteOp, addr, wdata,
                  input  rdata, ready, busy, misalign);
  modport slave  (input  req, we, byteOp, addr, wdata,
                  output rdata, ready, busy, misalign);
endinterface

// File: rtl/dm_byte_lane.sv
// Combinational byte-lane helpers: merge a byte into a word, and extract a sign-extended byte.
module dm_byte_lane
  import dm_responder_pkg::*;
(
  input  logic [31:0]       i_word,
  input  logic [7:0]        i_byte,
  input  logic [LANE_W-1:0] i_lane,
  output logic [31:0]       o_merged,
  output logic [31:0]       o_sext
);

  logic [7:0] w_sel;

  // Lane 0 is bits [7:0] (little-endian).
  always_comb begin
    o_merged = i_word;
    o_merged[{i_lane, 3'b000} +: 8] = i_byte;
  end

  assign w_sel  = i_word[{i_lane, 3'b000} +: 8];
  assign o_sext = {{24{w_sel[7]}}, w_sel};

endmodule

// File: rtl/dm_responder.sv
// Multicycle data-memory responder: one load/store at a time, WAIT_CYCLES wait states, one-cycle ready pulse.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  dm_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dm_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_accept;
  logic               r_we;
  logic               r_byte;
  logic [IDX_W-1:0]   r_idx;
  logic [LANE_W-1:0]  r_lane;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_misalign;
  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        w_rd_word;
  logic [31:0]        w_merged;
  logic [31:0]        w_sext;
  logic               w_unused_addr;

  // Upper address bits only matter through the modulo-depth wrap, i.e. not at all.
  assign w_unused_addr = ^bus.addr[31:IDX_W+2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_ACCESS;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_word = r_mem[r_idx];

  dm_byte_lane u_lane (
    .i_word   (w_rd_word),
    .i_byte   (r_wdata[7:0]),
    .i_lane   (r_lane),
    .o_merged (w_merged),
    .o_sext   (w_sext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_byte     <= 1'b0;
      r_idx      <= '0;
      r_lane     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= bus.we;
        r_byte  <= bus.byteOp;
        r_idx   <= bus.addr[IDX_W+1:2];
        r_lane  <= bus.addr[1:0];
        r_wdata <= bus.wdata;
      end
      if (r_state == S_ACCESS) begin
        r_misalign <= !r_byte && (r_lane != '0);
        if (!r_we) r_rdata <= r_byte ? w_sext : w_rd_word;
      end
    end
  end

  // Array has no reset; a reset that lands before ACCESS leaves the FSM out of ACCESS, so no write.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_we) r_mem[r_idx] <= r_byte ? w_merged : r_wdata;
  end

  assign bus.rdata    = r_rdata;
  assign bus.ready    = (r_state == S_RESP);
  assign bus.busy     = (r_state == S_WAIT) || (r_state == S_ACCESS);
  assign bus.misalign = r_misalign;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: three instances with WAIT_CYCLES 1, 0 and 4.
module tb_dm_responder;

  localparam int NI = 3;
  localparam int WC [NI] = '{1, 0, 4};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_v   [NI];
  logic        we_v    [NI];
  logic        bo_v    [NI];
  logic [31:0] addr_v  [NI];
  logic [31:0] wdata_v [NI];
  logic [31:0] rdata_v [NI];
  logic        ready_v [NI];
  logic        busy_v  [NI];
  logic        mis_v   [NI];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dm_responder_if bus ();
    assign bus.req    = req_v[g];
    assign bus.we     = we_v[g];
    assign bus.byteOp = bo_v[g];
    assign bus.addr   = addr_v[g];
    assign bus.wdata  = wdata_v[g];
    assign rdata_v[g] = bus.rdata;
    assign ready_v[g] = bus.ready;
    assign busy_v[g]  = bus.busy;
    assign mis_v[g]   = bus.misalign;
    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WC[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k; checks latency, busy window and pulse width.
  task automatic op(input int k, input bit w, input bit b, input logic [31:0] a,
                    input logic [31:0] d, output logic [31:0] rd, output logic mis);
    int n;
    bit busy_ok;
    @(negedge clk);
    req_v[k] = 1'b1; we_v[k] = w; bo_v[k] = b; addr_v[k] = a; wdata_v[k] = d;
    @(posedge clk); #1;
    req_v[k] = 1'b0; we_v[k] = ~w; bo_v[k] = ~b; addr_v[k] = $urandom; wdata_v[k] = $urandom;
    n = 1;
    busy_ok = 1'b1;
    while (ready_v[k] !== 1'b1 && n < 40) begin
      if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency_i%0d", k), n, 2 + WC[k]);
    check($sformatf("busy_window_i%0d", k), {31'b0, busy_ok}, 1);
    check($sformatf("busy_at_ready_i%0d", k), {31'b0, busy_v[k]}, 0);
    rd  = rdata_v[k];
    mis = mis_v[k];
    @(posedge clk); #1;
    check($sformatf("ready_width_i%0d", k), {31'b0, ready_v[k]}, 0);
  endtask

  // req held high: completions must be WAIT_CYCLES+3 apart.
  task automatic held(input int k);
    int last;
    int cnt;
    last = -1;
    cnt  = 0;
    @(negedge clk);
    req_v[k] = 1'b1; we_v[k] = 1'b1; bo_v[k] = 1'b0; addr_v[k] = 32'h80; wdata_v[k] = $urandom;
    for (int c = 0; c < 4 * (WC[k] + 3) + 2; c++) begin
      @(posedge clk); #1;
      if (ready_v[k] === 1'b1) begin
        if (last >= 0) check($sformatf("held_period_i%0d", k), c - last, WC[k] + 3);
        last = c;
        cnt++;
      end
    end
    req_v[k] = 1'b0;
    check($sformatf("held_count_i%0d", k), {31'b0, cnt >= 3}, 1);
    repeat (WC[k] + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        mis;
    logic [31:0] mm [8];
    logic [31:0] m_rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  by;
    int          wi;
    int          ln;
    int          cnt;
    bit          w;
    bit          b;

    for (int k = 0; k < NI; k++) begin
      req_v[k] = 1'b0; we_v[k] = 1'b0; bo_v[k] = 1'b0; addr_v[k] = '0; wdata_v[k] = '0;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_rdata_i%0d", k), rdata_v[k], 0);
      check($sformatf("rst_ready_i%0d", k), {31'b0, ready_v[k]}, 0);
      check($sformatf("rst_busy_i%0d", k), {31'b0, busy_v[k]}, 0);
      check($sformatf("rst_misalign_i%0d", k), {31'b0, mis_v[k]}, 0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Word and byte accesses, WAIT_CYCLES = 1
    op(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, mis);
    check("sw_misalign", {31'b0, mis}, 0);
    op(0, 0, 0, 32'h10, 32'h0, rd, mis);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    check("lw_misalign", {31'b0, mis}, 0);
    op(0, 1, 0, 32'h10, 32'h11223344, rd, mis);
    check("store_keeps_rdata", rd, 32'hDEADBEEF);
    op(0, 1, 1, 32'h12, 32'hABCDEF80, rd, mis);
    op(0, 0, 0, 32'h10, 32'h0, rd, mis);
    check("sb_merge", rd, 32'h11803344);
    op(0, 0, 1, 32'h12, 32'h0, rd, mis);
    check("lb_neg", rd, 32'hFFFFFF80);
    check("lb_misalign", {31'b0, mis}, 0);
    op(0, 0, 1, 32'h13, 32'h0, rd, mis);
    check("lb_pos", rd, 32'h00000011);
    op(0, 1, 0, 32'h4, 32'hCAFEF00D, rd, mis);
    op(0, 0, 0, 32'h1006, 32'h0, rd, mis);
    check("wrap_lw", rd, 32'hCAFEF00D);
    check("wrap_misalign", {31'b0, mis}, 1);

    // Latency and throughput with WAIT_CYCLES 0 and 4
    op(1, 1, 0, 32'h0, 32'h5A5A5A5A, rd, mis);
    op(1, 0, 0, 32'h0, 32'h0, rd, mis);
    check("w0_lw", rd, 32'h5A5A5A5A);
    op(2, 1, 0, 32'h0, 32'hA5A5A5A5, rd, mis);
    op(2, 0, 0, 32'h0, 32'h0, rd, mis);
    check("w4_lw", rd, 32'hA5A5A5A5);
    held(1);
    held(2);

    // req pulsed during WAIT is ignored
    @(negedge clk);
    req_v[2] = 1'b1; we_v[2] = 1'b1; bo_v[2] = 1'b0; addr_v[2] = 32'h84; wdata_v[2] = 32'h1;
    @(posedge clk); #1;
    req_v[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_v[2] = 1'b1;
    @(posedge clk); #1;
    req_v[2] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (ready_v[2] === 1'b1) cnt++;
    end
    check("wait_req_ignored", cnt, 1);

    // Reset during WAIT of a store aborts it
    op(2, 1, 0, 32'h40, 32'h55AA55AA, rd, mis);
    op(2, 0, 0, 32'h40, 32'h0, rd, mis);
    check("pre_reset_lw", rd, 32'h55AA55AA);
    @(negedge clk);
    req_v[2] = 1'b1; we_v[2] = 1'b1; bo_v[2] = 1'b0; addr_v[2] = 32'h40; wdata_v[2] = 32'h12345678;
    @(posedge clk); #1;
    req_v[2] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rdata", rdata_v[2], 0);
    check("abort_ready", {31'b0, ready_v[2]}, 0);
    check("abort_busy", {31'b0, busy_v[2]}, 0);
    check("abort_misalign", {31'b0, mis_v[2]}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_reset_busy", {31'b0, busy_v[2]}, 0);
    op(2, 0, 0, 32'h40, 32'h0, rd, mis);
    check("abort_no_write", rd, 32'h55AA55AA);

    // Randomized traffic on WAIT_CYCLES = 1 against a word-array model
    m_rd = 32'h0;
    for (int i = 0; i < 8; i++) begin
      mm[i] = $urandom;
      op(0, 1, 0, 32'h100 + 32'(i * 4), mm[i], rd, mis);
      check("init_keeps_rdata", rd, m_rd);
    end
    for (int i = 0; i < 40; i++) begin
      wi = int'($urandom_range(0, 7));
      ln = int'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      d  = $urandom;
      a  = 32'h100 + 32'(wi * 4 + ln) + ($urandom_range(0, 3) << 12);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      op(0, w, b, a, d, rd, mis);
      if (w) begin
        if (b) mm[wi] = (mm[wi] & ~(32'hFF << (8 * ln))) | ({24'h0, d[7:0]} << (8 * ln));
        else   mm[wi] = d;
      end else begin
        if (b) begin
          by   = 8'(mm[wi] >> (8 * ln));
          m_rd = {{24{by[7]}}, by};
        end else begin
          m_rd = mm[wi];
        end
      end
      check("rnd_rdata", rd, m_rd);
      check("rnd_misalign", {31'b0, mis}, {31'b0, (!b && ln != 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multicycle data-memory responder: the memory-side end of the controller's data-access interface. It accepts one load or store request at a time from the multicycle controller, inserts a configurable number of wait states, performs a word or byte access on an internal word array, and returns a one-cycle `ready` pulse. In the processor it sits between the controller/ALU datapath and the memory-access (MA) stage. Store data and byte sign extension for `sb`/`lb` are handled here.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 1: wait states inserted before each access, 0–15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe, sampled only in IDLE.
- `we`  in  1  1 = store (`sw`/`sb`), 0 = load (`lw`/`lb`).
- `byteOp`  in  1  1 = byte access, 0 = word access.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; for byte stores, bits [7:0] are used.
- `rdata`  out  32  load result, held until the next load completes.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from request acceptance through the cycle before `ready`.
- `misalign`  out  1  qualified by `ready`; word access with `addr[1:0]` != 0.

## Operation
- States: IDLE, WAIT, ACCESS, RESP. Reset state is IDLE.
- Reset values: `rdata` = 0, `ready` = 0, `busy` = 0, `misalign` = 0, wait counter = 0. Reset does not clear the memory array.
- **IDLE**
  - If `req` = 1, latch `we`, `byteOp`, `addr` and `wdata`.
  - Go to WAIT with the counter at `WAIT_CYCLES`-1. If `WAIT_CYCLES` = 0, go directly to ACCESS.
- **WAIT:** decrement the counter. Go to ACCESS on the cycle the counter is 0.
- **ACCESS:** perform the access on the latched request at the closing clock edge, then go to RESP.
  - Word index = latched `addr[log2(DEPTH_WORDS)+1:2]`. Out-of-range addresses wrap modulo the depth.
  - Word store: write the whole word.
  - Byte store: replace only lane `addr[1:0]` (lane 0 = bits [7:0], little-endian) with `wdata[7:0]`. Other lanes are unchanged.
  - Word load: `rdata` = stored word.
  - Byte load: `rdata` = sign-extended lane `addr[1:0]`.
  - Stores leave `rdata` unchanged.
  - A misaligned word access ignores `addr[1:0]`, still completes, and sets `misalign`.
- **RESP:** `ready` = 1 for exactly this cycle, `misalign` valid. Always go to IDLE.
- `req` outside IDLE is ignored; it is neither queued nor errored. A `req` held high through RESP is accepted on the following IDLE cycle as a new request.
- Inputs may change after acceptance; only the latched copies are used.

## Timing
- With `req` accepted at the end of cycle t:
  - `busy` is high in cycles t+1 … t+1+`WAIT_CYCLES`.
  - `ready` is high in cycle t+2+`WAIT_CYCLES`.
- `rdata` is updated at the same edge that raises `ready`.
- Back-to-back throughput: one access per `WAIT_CYCLES`+3 cycles.
- Reset asserted mid-operation:
  - Before the ACCESS edge: the request is aborted and no write occurs.
  - At or after the ACCESS edge: the write already done persists.
  - No `ready` pulse is produced for the aborted request.
- The memory write and the `rdata` update are synchronous to `clk` and are never affected combinationally by reset.

## Structure
- A shared package holds:
  - state encoding constants IDLE/WAIT/ACCESS/RESP (2-bit);
  - the lane-select width;
  - the `WAIT_CYCLES` counter width (4 bits).
- Sub-module `dm_byte_lane`, purely combinational:
  - insert-merge: old word, byte, lane → new word;
  - extract-sign-extend: word, lane → 32-bit result.
- Top level holds the FSM, the request latches, the wait counter and the memory array.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10, `WAIT_CYCLES`=1 → `rdata` = 0xDEADBEEF; `ready` exactly 3 cycles after acceptance; `misalign` = 0.
- Byte store 0x80 to addr 0x12 over word 0x11223344 → word reads 0x11803344. Byte load from 0x12 → 0xFFFFFF80. Byte load from 0x13 → 0x00000011.
- `WAIT_CYCLES`=0 and `WAIT_CYCLES`=4 → `ready` 2 and 6 cycles after acceptance. `req` held high continuously → one completion every 3 and 7 cycles respectively.
- Word load from addr 0x0000_1006 with `DEPTH_WORDS`=1024 → wraps to word index 1, returns that word, `misalign` = 1 with `ready`.
- `req` pulsed during WAIT → ignored, only one `ready`. Reset asserted during WAIT of a store → no memory change, all outputs return to 0, FSM in IDLE.
